// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port, decode handshake
// and backend redirect. The fetch unit takes the master view.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

interface fetch_unit_if #(
  parameter int ADDR_W = `MEMI_SIZE_LOG,
  parameter int INST_W = `INST_LEN
);
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output req_addr,
    input  resp_data,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  req_addr,
    output resp_data,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads the single-cycle
// instruction memory every cycle and buffers {pc, word} pairs in a small
// circular fetch queue that decode drains over valid/ready.
// Optional macro FETCH_PC_BOUND_EN: stop fetching after the word at the
// last PC instead of wrapping, and expose the halted flag as halted_o.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

// Invariant monitor for the fetch queue; instantiated by fetch_unit.
module fetch_unit_chk #(
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 3,
  parameter int FQ_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              redirect_valid,
  input logic              pop,
  input logic              out_valid,
  input logic [CNT_W-1:0]  count,
  input logic [ADDR_W-1:0] out_pc
);
  logic              have_last_r;
  logic [ADDR_W-1:0] last_pc_r;

  // Remember the last delivered PC since the most recent restart
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      have_last_r <= 1'b0;
      last_pc_r   <= {ADDR_W{1'b0}};
    end else if (pop) begin
      have_last_r <= 1'b1;
      last_pc_r   <= out_pc;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(FQ_DEPTH));
  a_valid_count: assert property (@(posedge clk) disable iff (rst)
    out_valid == (count != CNT_W'(0)));
  a_pc_order: assert property (@(posedge clk) disable iff (rst)
    (pop && have_last_r) |-> (out_pc == last_pc_r + ADDR_W'(1)));
endmodule

module fetch_unit #(
  parameter int ADDR_W   = `MEMI_SIZE_LOG,
  parameter int INST_W   = `INST_LEN,
  parameter int FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_unit_if.master              bus,
  input  logic                      fetch_en,
  output logic [$clog2(FQ_DEPTH):0] fq_count
`ifdef FETCH_PC_BOUND_EN
  ,
  output logic                      halted_o
`endif
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef FETCH_PC_BOUND_EN
  localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};
`endif

  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [PTR_W-1:0]  head_r, head_nxt_s;
  logic [PTR_W-1:0]  tail_r, tail_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              halted_s;
`ifdef FETCH_PC_BOUND_EN
  logic              halted_r, halted_nxt_s;
`endif

  logic [ADDR_W-1:0] ent_pc_r   [FQ_DEPTH];
  logic [INST_W-1:0] ent_inst_r [FQ_DEPTH];

  logic pop_s;
  logic can_enq_s;
  logic enq_s;

`ifdef FETCH_PC_BOUND_EN
  assign halted_s = halted_r;
  assign halted_o = halted_r;
`else
  assign halted_s = 1'b0;
`endif

  // Memory address tracks the PC; queue head is read straight from storage
  assign bus.req_addr  = pc_r;
  assign bus.out_valid = (count_r != CNT_W'(0));
  assign bus.out_inst  = ent_inst_r[head_r];
  assign bus.out_pc    = ent_pc_r[head_r];
  assign fq_count      = count_r;

  // A full queue may still accept a word when its head leaves this cycle
  assign pop_s     = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
  assign can_enq_s = fetch_en & ~halted_s & ((count_r < CNT_W'(FQ_DEPTH)) | pop_s);
  assign enq_s     = can_enq_s & ~bus.redirect_valid;

  // Next PC, pointers, occupancy and halt flag; redirect squashes everything
  always_comb begin
    pc_nxt_s    = pc_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
`ifdef FETCH_PC_BOUND_EN
    halted_nxt_s = halted_r;
`endif
    if (bus.redirect_valid) begin
      pc_nxt_s    = bus.redirect_pc;
      head_nxt_s  = {PTR_W{1'b0}};
      tail_nxt_s  = {PTR_W{1'b0}};
      count_nxt_s = {CNT_W{1'b0}};
`ifdef FETCH_PC_BOUND_EN
      halted_nxt_s = 1'b0;
`endif
    end else begin
      if (enq_s) begin
        tail_nxt_s = tail_r + PTR_W'(1);
`ifdef FETCH_PC_BOUND_EN
        if (pc_r == PC_MAX) begin
          halted_nxt_s = 1'b1;
        end else begin
          pc_nxt_s = pc_r + ADDR_W'(1);
        end
`else
        pc_nxt_s = pc_r + ADDR_W'(1);
`endif
      end else begin
        tail_nxt_s = tail_r;
      end
      if (pop_s) begin
        head_nxt_s = head_r + PTR_W'(1);
      end else begin
        head_nxt_s = head_r;
      end
      if (enq_s && !pop_s) begin
        count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !enq_s) begin
        count_nxt_s = count_r - CNT_W'(1);
      end else begin
        count_nxt_s = count_r;
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= {ADDR_W{1'b0}};
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
`ifdef FETCH_PC_BOUND_EN
      halted_r <= 1'b0;
`endif
    end else begin
      pc_r    <= pc_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
`ifdef FETCH_PC_BOUND_EN
      halted_r <= halted_nxt_s;
`endif
    end
  end

  // Queue storage: cleared on reset, {pc, word} written at tail on enqueue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ent_pc_r[i]   <= {ADDR_W{1'b0}};
        ent_inst_r[i] <= {INST_W{1'b0}};
      end
    end else if (enq_s) begin
      ent_pc_r[tail_r]   <= pc_r;
      ent_inst_r[tail_r] <= bus.resp_data;
    end
  end

  fetch_unit_chk #(
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .FQ_DEPTH(FQ_DEPTH)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(bus.redirect_valid),
    .pop           (pop_s),
    .out_valid     (bus.out_valid),
    .count         (count_r),
    .out_pc        (bus.out_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam int ADDR_W = 3;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int NPC    = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic fetch_en;
  logic [2:0] fq_count;
`ifdef FETCH_PC_BOUND_EN
  logic halted_o;
`endif

  fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .FQ_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fetch_en(fetch_en),
    .fq_count(fq_count)
`ifdef FETCH_PC_BOUND_EN
    ,
    .halted_o(halted_o)
`endif
  );

  always #5 clk = ~clk;

  logic [INST_W-1:0] imem [NPC];
  assign bus.resp_data = imem[bus.req_addr];

  // Reference model state
  ent_t              q[$];
  logic [ADDR_W-1:0] m_pc;
  logic              m_halted;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_update();
    bit pop, enq;
    if (rst) begin
      q.delete();
      m_pc = '0;
      m_halted = 1'b0;
    end else if (bus.redirect_valid) begin
      q.delete();
      m_pc = bus.redirect_pc;
      m_halted = 1'b0;
    end else begin
      pop = (q.size() != 0) && bus.out_ready;
      enq = fetch_en && !m_halted && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (enq) begin
        q.push_back({m_pc, imem[m_pc]});
`ifdef FETCH_PC_BOUND_EN
        if (m_pc == ADDR_W'(NPC - 1)) m_halted = 1'b1;
        else m_pc = m_pc + 3'd1;
`else
        m_pc = m_pc + 3'd1;
`endif
      end
    end
  endtask

  task automatic check_all();
    ent_t e;
    check_eq("req_addr", 64'(bus.req_addr), 64'(m_pc));
    check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check_eq("fq_count", 64'(fq_count), 64'(q.size()));
    if (q.size() != 0) begin
      e = q[0];
      check_eq("out_pc", 64'(bus.out_pc), 64'(e.pc));
      check_eq("out_inst", 64'(bus.out_inst), 64'(e.inst));
    end
`ifdef FETCH_PC_BOUND_EN
    check_eq("halted_o", 64'(halted_o), 64'(m_halted));
`endif
  endtask

  // Apply inputs, clock once, update the model, compare on the falling edge
  task automatic step(input logic r, input logic fe, input logic rdy,
                      input logic rv, input logic [ADDR_W-1:0] rpc);
    rst = r;
    fetch_en = fe;
    bus.out_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) imem[i] = 32'h10 + 32'(i);
    rst = 1'b1;
    fetch_en = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_count", 64'(fq_count), 64'd0);
    check_eq("rst_addr", 64'(bus.req_addr), 64'd0);
    check_eq("rst_inst", 64'(bus.out_inst), 64'd0);
    check_eq("rst_pc", 64'(bus.out_pc), 64'd0);

    // Streaming at full throughput
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      check_eq("stream_pc", 64'(bus.out_pc), 64'(i));
      check_eq("stream_inst", 64'(bus.out_inst), 64'(32'h10 + 32'(i)));
      check_eq("stream_count", 64'(fq_count), 64'd1);
    end

    // Backpressure until full, then drain with a simultaneous push
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("bp_count", 64'(fq_count), 64'd4);
    check_eq("bp_addr", 64'(bus.req_addr), 64'd4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("full_pop_count", 64'(fq_count), 64'd4);
    check_eq("full_pop_pc", 64'(bus.out_pc), 64'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);

    // Redirect with a partly filled queue
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("pre_redir_count", 64'(fq_count), 64'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
    check_eq("redir_valid", 64'(bus.out_valid), 64'd0);
    check_eq("redir_count", 64'(fq_count), 64'd0);
    check_eq("redir_addr", 64'(bus.req_addr), 64'd5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("redir_first_pc", 64'(bus.out_pc), 64'd5);

    // PC wrap (or halt) at the top of the address space
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("wrap_pc7", 64'(bus.out_pc), 64'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
`ifdef FETCH_PC_BOUND_EN
    check_eq("halt_valid", 64'(bus.out_valid), 64'd0);
    check_eq("halt_flag", 64'(halted_o), 64'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("halt_hold", 64'(bus.out_valid), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("halt_restart_pc", 64'(bus.out_pc), 64'd2);
    check_eq("halt_cleared", 64'(halted_o), 64'd0);
`else
    check_eq("wrap_pc0", 64'(bus.out_pc), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("wrap_pc1", 64'(bus.out_pc), 64'd1);
`endif

    // Reset mid-stream
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_count", 64'(fq_count), 64'd0);
    check_eq("mid_rst_addr", 64'(bus.req_addr), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("mid_rst_pc", 64'(bus.out_pc), 64'd0);

    // Random traffic with fresh memory contents
    for (int i = 0; i < NPC; i++) imem[i] = $urandom;
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(63) == 0),
           1'($urandom_range(7) != 0),
           1'($urandom_range(2) != 0),
           1'($urandom_range(15) == 0),
           3'($urandom_range(NPC - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
